usr_seq_ctrl: RTL
=================

Name: usr_seq_ctrl

Overview:
- Command sequencer for the 4-bit universal shift register (usr) datapath: accepts LOAD / shift-right / shift-left / load-then-shift commands over a valid/ready handshake.
- Drives the usr mode selects (s1,s0), parallel input (pin) and serial input (sin) cycle by cycle.
- Counts shift steps and returns the final usr parallel output as a response held until accepted.
- Sits between a host/bus agent and one usr instance; it is the only driver of the usr control pins.

Parameters:
- WIDTH, 4, usr data width.
- CNT_W, 3, width of the shift-count field; max count = 2**CNT_W-1.

Ports:
- clk  in  1  clock; usr shares this clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk.
- cmd_op  in  2  00 LOAD, 01 SHR, 10 SHL, 11 LDSH (load, then shift right).
- cmd_fill  in  2  serial fill: 00 zero, 01 one, 10 rotate, 11 reserved (treated as zero).
- cmd_cnt  in  CNT_W  number of shift steps.
- cmd_data  in  WIDTH  parallel load value.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready.
- rsp_data  out  WIDTH  usr_q captured at completion.
- busy  out  1  high in every state except IDLE.
- usr_s1, usr_s0  out  1 each  usr mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- usr_pin  out  WIDTH  usr parallel input.
- usr_sin  out  1  usr serial input.
- usr_q  in  WIDTH  usr parallel output.

Behaviour:
- usr convention:
  - SHR: q <= {sin, q[W-1:1]}.
  - SHL: q <= {q[W-2:0], sin}.
  - LOAD: q <= pin.
  - HOLD: q unchanged.
  - All update at posedge clk.
- Reset (async, rst_n=0):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0.
  - usr_s1=usr_s0=0 (hold), usr_pin=0, usr_sin=0.
  - Latched command registers cleared.
  - A reset mid-operation abandons the command; no response is produced.
- States:
  - IDLE: cmd_ready=1. On accept (cycle T), latch op/fill/cnt/data.
    - LOAD or LDSH: go to LOAD.
    - SHR/SHL with cnt>0: go to SHIFT.
    - SHR/SHL with cnt=0: go to DONE.
  - LOAD (one cycle, T+1): s=11, pin=data.
    - Go to SHIFT if op=LDSH and cnt>0, else DONE.
  - SHIFT (exactly cnt cycles): s=01 for SHR/LDSH, 10 for SHL; remaining-count decrements each cycle.
    - Go to DONE on the cycle remaining=1.
  - DONE: s=00. Capture rsp_data=usr_q on entry and assert rsp_valid.
    - Hold rsp_valid and rsp_data stable until rsp_ready; then return to IDLE the next cycle.
- Latency (accept at T, rsp_valid first high):
  - LOAD: T+2.
  - SHR/SHL: T+cnt+1.
  - LDSH: T+cnt+2.
- usr_s1/usr_s0/usr_pin are decoded from registered state only; no combinational path from cmd_* to usr_*.
- usr_pin=0 outside LOAD.
- usr_sin is combinational, meaningful only in SHIFT:
  - zero fill: 0.
  - one fill: 1.
  - rotate: usr_q[0] for SHR/LDSH, usr_q[WIDTH-1] for SHL.
  - Outside SHIFT: 0.
- cmd_ready=0 in LOAD, SHIFT and DONE. A command is never accepted in the same cycle a response is consumed; earliest next accept is the cycle after return to IDLE.
- cmd_cnt has no overflow handling: the full range 0..2**CNT_W-1 is legal. Counts >= WIDTH with zero/one fill saturate the register to all-0/all-1.
- cmd_valid deasserting while cmd_ready=0 has no effect.

Decomposition:
- Package usr_pkg:
  - usr_mode_e {HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11}
  - usr_op_e {OP_LOAD, OP_SHR, OP_SHL, OP_LDSH}
  - usr_fill_e {FILL_ZERO, FILL_ONE, FILL_ROT, FILL_RSVD}
  - ctrl_state_e {IDLE, LOADS, SHIFT, DONE}
  - default WIDTH/CNT_W constants
- No sub-module: the FSM, down-counter and fill mux are all in usr_seq_ctrl. The bench instantiates it alongside the existing usr via the usr interface.

Test Plan:
- LOAD data=1010 -> T+1 s=11, pin=1010; T+2 rsp_valid=1, rsp_data=1010, s=00.
- After q=1010, SHR cnt=3 fill=one -> q 1101, 1110, 1111; rsp_data=1111 at T+4; sin=1 for exactly 3 cycles.
- After q=1010, SHL cnt=1 fill=rotate -> rsp_data=0101 at T+2. Then LDSH data=1001 cnt=2 rotate -> 1001, 1100, 0110; rsp_data=0110 at T+4.
- SHR cnt=0 with q=0110 -> no shift cycles; rsp_valid at T+1, rsp_data=0110, s stays 00.
- Backpressure: rsp_ready=0 for 3 cycles after LOAD 0011 -> rsp_valid and rsp_data=0011 stable, cmd_ready=0, s=00, busy=1. Then rsp_ready=1 -> IDLE next cycle; a new cmd is accepted the following edge.
- rst_n pulled low during SHIFT of cnt=7 -> all outputs at reset values immediately (async), no rsp_valid. After release, LOAD 1111 completes normally at T+2.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_pkg
//  Description : Shared types and default sizes for the universal shift
//                register command sequencer (usr_seq_ctrl).
//                - usr_mode_e   : encoding of the usr {s1,s0} mode pins
//                - usr_op_e     : command opcodes accepted on cmd_op
//                - usr_fill_e   : serial fill policy selected by cmd_fill
//                - ctrl_state_e : sequencer FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    // Default datapath width and shift-count field width.
    localparam int unsigned c_DEF_WIDTH = 4;
    localparam int unsigned c_DEF_CNT_W = 3;

    // Mode select applied to the usr as {s1,s0}.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } usr_mode_e;

    // Command opcodes.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LDSH = 2'b11
    } usr_op_e;

    // Serial fill policy. FILL_RSVD behaves exactly like FILL_ZERO.
    typedef enum logic [1:0] {
        FILL_ZERO = 2'b00,
        FILL_ONE  = 2'b01,
        FILL_ROT  = 2'b10,
        FILL_RSVD = 2'b11
    } usr_fill_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOADS = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } ctrl_state_e;

    // Shift direction used for an opcode while in SHIFT.
    // LDSH always shifts right after its load cycle.
    function automatic usr_mode_e shift_mode(input usr_op_e op);
        return (op == OP_SHL) ? SHL : SHR;
    endfunction

    // True for opcodes that start with a parallel load cycle.
    function automatic logic op_has_load(input usr_op_e op);
        return (op == OP_LOAD) || (op == OP_LDSH);
    endfunction

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usr_seq_ctrl
//  Description : Command sequencer for a universal shift register (usr).
//                Accepts LOAD / SHR / SHL / LDSH commands over a valid/ready
//                handshake, drives the usr control pins cycle by cycle,
//                counts shift steps and returns the final usr contents as a
//                response held until accepted.
//
//  Ports
//    clk        in   clock, shared with the usr
//    rst_n      in   asynchronous active-low reset
//    cmd_valid  in   command offered
//    cmd_ready  out  sequencer idle, command taken on valid & ready
//    cmd_op     in   00 LOAD, 01 SHR, 10 SHL, 11 LDSH
//    cmd_fill   in   00 zero, 01 one, 10 rotate, 11 reserved (zero)
//    cmd_cnt    in   number of shift steps
//    cmd_data   in   parallel load value
//    rsp_valid  out  result available
//    rsp_ready  in   result consumed on valid & ready
//    rsp_data   out  usr contents at completion
//    busy       out  high whenever not IDLE
//    usr_s1/s0  out  usr mode select (00 hold, 01 SHR, 10 SHL, 11 load)
//    usr_pin    out  usr parallel input
//    usr_sin    out  usr serial input
//    usr_q      in   usr parallel output
//
//  Revision    : 1.0 - initial release
// ============================================================================
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned CNT_W = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_fill,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,

    output logic             busy,

    output logic             usr_s1,
    output logic             usr_s0,
    output logic [WIDTH-1:0] usr_pin,
    output logic             usr_sin,
    input  logic [WIDTH-1:0] usr_q
);

    // ------------------------------------------------------------------
    // State and latched command
    // ------------------------------------------------------------------
    ctrl_state_e      state_q,    state_d;
    usr_op_e          op_q,       op_d;
    usr_fill_e        fill_q,     fill_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] data_q,     data_d;

    // Response capture. The last shift lands on the same edge that enters
    // DONE, so the final usr value is only visible during the first DONE
    // cycle. rsp_data is passed through from usr_q in that cycle and the
    // register takes over from the second DONE cycle onwards.
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_held_q, rsp_held_d;

    logic             w_cmd_acc;
    usr_mode_e        w_mode;

    assign w_cmd_acc = cmd_valid && (state_q == IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (w_cmd_acc) begin
                    op_d   = usr_op_e'(cmd_op);
                    fill_d = usr_fill_e'(cmd_fill);
                    cnt_d  = cmd_cnt;
                    data_d = cmd_data;
                    if (op_has_load(usr_op_e'(cmd_op))) begin
                        state_d = LOADS;
                    end else if (cmd_cnt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            LOADS: begin
                // A plain LOAD ignores its count field.
                if ((op_q == OP_LDSH) && (cnt_q != '0)) begin
                    state_d = SHIFT;
                end else begin
                    state_d = DONE;
                end
            end

            SHIFT: begin
                // cnt_q holds the number of shift cycles still to run,
                // including the current one.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_held_d = 1'b0;
        if (state_q == DONE) begin
            rsp_held_d = 1'b1;
            if (!rsp_held_q) begin
                rsp_data_d = usr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_LOAD;
            fill_q     <= FILL_ZERO;
            cnt_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_held_q <= rsp_held_d;
        end
    end

    // ------------------------------------------------------------------
    // usr control decode. Mode and parallel input depend on registered
    // state only; the serial input additionally follows usr_q so that
    // rotate fill tracks the live register contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_mode  = HOLD;
        usr_pin = '0;
        usr_sin = 1'b0;

        case (state_q)
            LOADS: begin
                w_mode  = LOAD;
                usr_pin = data_q;
            end

            SHIFT: begin
                w_mode = shift_mode(op_q);
                case (fill_q)
                    FILL_ONE: usr_sin = 1'b1;
                    // Rotate feeds back the bit that is about to fall out.
                    FILL_ROT: usr_sin = (op_q == OP_SHL) ? usr_q[WIDTH-1] : usr_q[0];
                    default:  usr_sin = 1'b0;
                endcase
            end

            default: begin
                w_mode = HOLD;
            end
        endcase
    end

    assign {usr_s1, usr_s0} = w_mode;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = ((state_q == DONE) && !rsp_held_q) ? usr_q : rsp_data_q;

endmodule : usr_seq_ctrl
`default_nettype wire
